// File: rtl/red_barrett_pipe.sv
// Three-stage pipelined Barrett reduction of a 2*QW-bit product modulo an odd prime Q.
// Valid/ready handshaking at both ends; bubbles collapse; the tag travels with each operand.
module red_barrett_pipe #(
  parameter int unsigned Q     = 3329,
  parameter int unsigned QW    = 12,
  parameter int unsigned TAG_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [2*QW-1:0]   product_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [QW-1:0]     result_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o
);

  localparam int unsigned K  = 2 * QW;
  localparam int unsigned TW = 3 * QW + 1;
  localparam logic [K:0]  POW    = (K+1)'(1) << K;
  localparam logic [K:0]  M_FULL = POW / (K+1)'(Q);
  localparam logic [QW:0] M      = M_FULL[QW:0];
  localparam logic [QW:0] QC     = (QW+1)'(Q);

  logic              v1, v2, v3;
  logic              space1, space2, space3;
  logic [2*QW-1:0]   x1;
  logic [TW-1:0]     t1;
  logic [TAG_W-1:0]  tag1, tag2, tag3;
  logic [QW:0]       r2;
  logic [QW-1:0]     res3;
  logic [TW-1:0]     t_next;
  logic [QW:0]       q_est;
  logic [QW:0]       r_next;
  logic [QW:0]       r_corr;
  logic              unused_bits;

  // A stage can take new data when it is empty or its contents move on this cycle.
  assign space3 = !v3 || ready_i;
  assign space2 = !v2 || space3;
  assign space1 = !v1 || space2;

  assign ready_o  = space1;
  assign valid_o  = v3;
  assign result_o = res3;
  assign tag_o    = tag3;
  assign busy_o   = v1 || v2 || v3;

  assign t_next = TW'(product_i) * TW'(M);
  assign q_est  = t1[TW-1:K];
  // The true remainder is below 2Q < 2^(QW+1), so computing modulo 2^(QW+1) is exact.
  assign r_next = x1[QW:0] - q_est * QC;
  assign r_corr = (r2 >= QC) ? r2 - QC : r2;

  assign unused_bits = ^{t1[K-1:0], x1[2*QW-1:QW+1], r_corr[QW]};

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (space1) v1 <= valid_i;
      if (space2) v2 <= v1;
      if (space3) v3 <= v2;
    end
  end

  // NOTE: S1/S2 datapath registers carry no reset; their valid bits already mask stale contents.
  always_ff @(posedge clk_i) begin
    if (valid_i && space1) begin
      x1   <= product_i;
      t1   <= t_next;
      tag1 <= tag_i;
    end
    if (v1 && space2) begin
      r2   <= r_next;
      tag2 <= tag1;
    end
  end

  // The output stage is reset so result_o and tag_o read zero while in reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res3 <= '0;
      tag3 <= '0;
    end else if (v2 && space3) begin
      res3 <= r_corr[QW-1:0];
      tag3 <= tag2;
    end
  end

endmodule

// File: tb/tb_red_barrett_pipe.sv
// Directed and lightly randomised checks for red_barrett_pipe: default Q=3329 plus a
// second instance with Q=8380417, QW=23 for the wide boundary set.
module tb_red_barrett_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default instance
  logic [23:0] product;
  logic [3:0]  tag_in, tag_out;
  logic        valid_in, ready_out, valid_out, ready_in, busy;
  logic [11:0] result;

  // Wide instance
  localparam longint unsigned Q2 = 64'd8380417;
  logic [45:0] p2;
  logic [3:0]  tg2_in, tg2_out;
  logic        vi2, ro2, vo2, ri2, busy2;
  logic [22:0] res2;

  int checks = 0;
  int errors = 0;

  red_barrett_pipe dut (
    .clk_i(clk), .rst_i(rst), .product_i(product), .tag_i(tag_in), .valid_i(valid_in),
    .ready_o(ready_out), .result_o(result), .tag_o(tag_out), .valid_o(valid_out),
    .ready_i(ready_in), .busy_o(busy)
  );

  red_barrett_pipe #(.Q(8380417), .QW(23), .TAG_W(4)) dut_wide (
    .clk_i(clk), .rst_i(rst), .product_i(p2), .tag_i(tg2_in), .valid_i(vi2),
    .ready_o(ro2), .result_o(res2), .tag_o(tg2_out), .valid_o(vo2),
    .ready_i(ri2), .busy_o(busy2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [23:0] svec[5] = '{24'd0, 24'd3329, 24'd6657, 24'd11075584, 24'd16777215};
  logic [11:0] sexp[5] = '{12'd0, 12'd0, 12'd3328, 12'd1, 12'd2384};
  logic [23:0] stv[4]  = '{24'd100, 24'd16652, 24'd16777214, 24'd3330};
  logic [45:0] bvec[6];
  logic [15:0] sb[$];
  logic [15:0] exp_word;
  int stale;

  initial begin
    product = '0; tag_in = '0; valid_in = 1'b0; ready_in = 1'b1;
    p2 = '0; tg2_in = '0; vi2 = 1'b0; ri2 = 1'b1;

    // Reset state
    #1;
    check("rst_valid", valid_out, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_tag", tag_out, 0);
    check("rst_ready", ready_out, 1);

    // Offers during reset must not be recorded
    valid_in = 1'b1; product = 24'd5; tag_in = 4'd3;
    step(); step();
    check("rst_no_xfer", busy, 0);

    // First edge after release accepts; result appears three edges later
    rst = 1'b0;
    step();
    check("first_accept", busy, 1);
    valid_in = 1'b0;
    step();
    check("first_lat2", valid_out, 0);
    step();
    check("first_valid", valid_out, 1);
    check("first_result", result, 5);
    check("first_tag", tag_out, 3);
    step();
    check("first_drain", busy, 0);

    // Back-to-back stream at full throughput
    for (int c = 0; c < 9; c++) begin
      if (c < 5) begin
        product = svec[c]; tag_in = 4'(c + 1); valid_in = 1'b1;
        check("stream_ready", ready_out, 1);
      end else begin
        valid_in = 1'b0;
      end
      step();
      if (c >= 2 && c < 7) begin
        check("stream_valid", valid_out, 1);
        check("stream_result", result, sexp[c-2]);
        check("stream_tag", tag_out, 4'(c - 1));
      end else begin
        check("stream_idle", valid_out, 0);
      end
    end
    check("stream_busy_end", busy, 0);

    // Stall: three accepted, the fourth waits until the first result leaves
    ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      product = stv[i]; tag_in = 4'(9 + i); valid_in = 1'b1;
      #1;
      check("stall_ready", ready_out, 1);
      step();
    end
    product = stv[3]; tag_in = 4'd12;
    #1;
    check("stall_full", ready_out, 0);
    step();
    check("stall_hold_v", valid_out, 1);
    check("stall_hold_r", result, 100);
    check("stall_hold_t", tag_out, 9);
    step();
    check("stall_hold_r2", result, 100);
    check("stall_hold_t2", tag_out, 9);
    ready_in = 1'b1;
    #1;
    check("stall_ready_comb", ready_out, 1);
    step();
    valid_in = 1'b0;
    check("stall_out_b", result, 7);
    check("stall_tag_b", tag_out, 10);
    step();
    check("stall_out_c", result, 2383);
    check("stall_tag_c", tag_out, 11);
    step();
    check("stall_out_d", result, 1);
    check("stall_tag_d", tag_out, 12);
    check("stall_valid_d", valid_out, 1);
    step();
    check("stall_empty", busy, 0);

    // Reset with three entries in flight
    ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      product = 24'(1000 * (i + 1)); tag_in = 4'(i + 1); valid_in = 1'b1;
      step();
    end
    valid_in = 1'b0;
    check("inflight_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_valid", valid_out, 0);
    check("async_busy", busy, 0);
    check("async_result", result, 0);
    check("async_tag", tag_out, 0);
    check("async_ready", ready_out, 1);
    step();
    rst = 1'b0;
    ready_in = 1'b1;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (valid_out) stale++;
    end
    check("no_stale", stale, 0);

    // Random handshake against a scoreboard
    for (int cyc = 0; cyc < 600; cyc++) begin
      valid_in = ($urandom_range(0, 3) != 0);
      product  = 24'($urandom);
      tag_in   = 4'($urandom);
      ready_in = ($urandom_range(0, 3) != 0);
      #1;
      if (valid_out && ready_in) begin
        if (sb.size() == 0) check("rand_spurious", 1, 0);
        else begin
          exp_word = sb.pop_front();
          check("rand_out", {tag_out, result}, exp_word);
        end
      end
      if (valid_in && ready_out) sb.push_back({tag_in, 12'(product % 24'd3329)});
      step();
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (valid_out && ready_in) begin
        if (sb.size() == 0) check("drain_spurious", 1, 0);
        else begin
          exp_word = sb.pop_front();
          check("drain_out", {tag_out, result}, exp_word);
        end
      end
      step();
    end
    check("rand_all_out", sb.size(), 0);

    // Wide parameter set: boundary operands, latency still three
    bvec[0] = '0;
    bvec[1] = 46'(Q2 - 1);
    bvec[2] = 46'(Q2);
    bvec[3] = 46'(2 * Q2 - 1);
    bvec[4] = 46'((Q2 - 1) * (Q2 - 1));
    bvec[5] = '1;
    for (int c = 0; c < 9; c++) begin
      if (c < 6) begin
        p2 = bvec[c]; tg2_in = 4'(c); vi2 = 1'b1;
      end else begin
        vi2 = 1'b0;
      end
      step();
      if (c >= 2 && c < 8) begin
        check("wide_valid", vo2, 1);
        check("wide_result", res2, 64'(bvec[c-2]) % Q2);
        check("wide_tag", tg2_out, 4'(c - 2));
      end else begin
        check("wide_idle", vo2, 0);
      end
    end
    check("wide_busy_end", busy2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
